// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and helpers for the shared system bus
package bus_pkg;

    // Arbitration policy selected per bus instance
    typedef enum logic {
        ArbFixed      = 1'b0,
        ArbRoundRobin = 1'b1
    } arb_mode_e;

    // Index fields are stored at a fixed width so one entry type serves any
    // bus size up to 256 hosts and 255 devices.
    localparam int IdxW = 8;

    // One in-flight transaction: who asked, and which target will answer
    typedef struct packed {
        logic [IdxW-1:0] host;
        logic [IdxW-1:0] target;
    } out_entry_t;

    // Candidate host for round-robin search position 'offset' after 'last'
    function automatic int rr_index(input int last, input int offset, input int n);
        return (last + 1 + offset) % n;
    endfunction

endpackage

// File: rtl/bus_outstanding_fifo.sv
// rtl/bus_outstanding_fifo.sv - synchronous FIFO tracking granted-but-unanswered transactions
module bus_outstanding_fifo #(
    parameter int Depth = 2,
    parameter int Width = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [Width-1:0]           head_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;

    // Pointers wrap at Depth, which need not be a power of two
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Next pointer and occupancy; simultaneous push and pop leaves count unchanged
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bus_shared_rr.sv
// rtl/bus_shared_rr.sv - shared request/grant bus with arbitration and in-order pipelining
module bus_shared_rr
    import bus_pkg::*;
#(
    parameter int        NrHosts        = 2,
    parameter int        NrDevices      = 5,
    parameter int        DataWidth      = 32,
    parameter int        AddressWidth   = 32,
    parameter int        MaxOutstanding = 2,
    parameter arb_mode_e ArbMode        = ArbRoundRobin
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      host_req_i             [NrHosts],
    output logic                      host_gnt_o             [NrHosts],
    input  logic [AddressWidth-1:0]   host_addr_i            [NrHosts],
    input  logic                      host_we_i              [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i              [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i           [NrHosts],
    output logic                      host_rvalid_o          [NrHosts],
    output logic [DataWidth-1:0]      host_rdata_o           [NrHosts],
    output logic                      host_err_o             [NrHosts],

    output logic                      device_req_o           [NrDevices],
    output logic [AddressWidth-1:0]   device_addr_o          [NrDevices],
    output logic                      device_we_o            [NrDevices],
    output logic [DataWidth/8-1:0]    device_be_o            [NrDevices],
    output logic [DataWidth-1:0]      device_wdata_o         [NrDevices],
    input  logic                      device_rvalid_i        [NrDevices],
    input  logic [DataWidth-1:0]      device_rdata_i         [NrDevices],
    input  logic                      device_err_i           [NrDevices],

    input  logic [AddressWidth-1:0]   cfg_device_addr_base_i [NrDevices],
    input  logic [AddressWidth-1:0]   cfg_device_addr_mask_i [NrDevices]
);

    localparam int HostW  = (NrHosts > 1) ? $clog2(NrHosts) : 1;
    localparam int TgtW   = $clog2(NrDevices + 1);
    localparam int CntW   = $clog2(MaxOutstanding + 1);
    localparam int ErrTgt = NrDevices;
    localparam int EntW   = $bits(out_entry_t);

    logic [TgtW-1:0]  host_tgt [NrHosts];
    logic [NrHosts-1:0] eligible;
    int               cand;
    logic             gnt_valid;
    logic [HostW-1:0] gnt_host;
    logic [TgtW-1:0]  gnt_tgt;

    logic [HostW-1:0] last_gnt_q, last_gnt_d;
    logic [TgtW-1:0]  cur_target_q, cur_target_d;
    logic             err_rvalid_q, err_rvalid_d;

    out_entry_t       push_entry;
    out_entry_t       head_entry;
    logic [EntW-1:0]  head_bits;
    logic [CntW-1:0]  out_count;

    logic             rsp_valid;
    logic [DataWidth-1:0] rsp_rdata;
    logic             rsp_err;
    logic             pop;

    // Address decode per host; lowest matching device wins, no match hits the error target
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_tgt[h] = TgtW'(ErrTgt);
            for (int d = NrDevices - 1; d >= 0; d--) begin
                if ((host_addr_i[h] & cfg_device_addr_mask_i[d]) == cfg_device_addr_base_i[d]) begin
                    host_tgt[h] = TgtW'(d);
                end
            end
        end
    end

    // A host may issue only while there is room and it would not mix targets in flight
    always_comb begin
        eligible = '0;
        for (int h = 0; h < NrHosts; h++) begin
            eligible[h] = !rst_i && host_req_i[h]
                       && (out_count < CntW'(MaxOutstanding))
                       && ((out_count == '0) || (host_tgt[h] == cur_target_q));
        end
    end

    // Pick at most one host; ineligible hosts are skipped rather than blocking the search
    always_comb begin
        gnt_valid = 1'b0;
        gnt_host  = '0;
        cand      = 0;
        for (int i = 0; i < NrHosts; i++) begin
            if (ArbMode == ArbRoundRobin) begin
                cand = rr_index(int'(last_gnt_q), i, NrHosts);
            end else begin
                cand = i;
            end
            if (!gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_host  = HostW'(cand);
            end
        end
        gnt_tgt = host_tgt[gnt_host];
    end

    // Forward the granted host's fields to its device; everything else is driven to zero
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_gnt_o[h] = gnt_valid && (gnt_host == HostW'(h));
        end
        for (int d = 0; d < NrDevices; d++) begin
            device_req_o[d]   = gnt_valid && (gnt_tgt == TgtW'(d));
            device_addr_o[d]  = device_req_o[d] ? host_addr_i[gnt_host]  : '0;
            device_we_o[d]    = device_req_o[d] && host_we_i[gnt_host];
            device_be_o[d]    = device_req_o[d] ? host_be_i[gnt_host]    : '0;
            device_wdata_o[d] = device_req_o[d] ? host_wdata_i[gnt_host] : '0;
        end
    end

    // Record who was granted and which target owes the answer
    always_comb begin
        push_entry        = '0;
        push_entry.host   = IdxW'(gnt_host);
        push_entry.target = IdxW'(gnt_tgt);
    end

    bus_outstanding_fifo #(
        .Depth (MaxOutstanding),
        .Width (EntW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (gnt_valid),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_bits),
        .count_o     (out_count)
    );

    assign head_entry = out_entry_t'(head_bits);

    // Select the response source owed by the oldest transaction
    always_comb begin
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        if (head_entry.target == IdxW'(ErrTgt)) begin
            rsp_valid = err_rvalid_q;
            rsp_err   = 1'b1;
        end
        for (int d = 0; d < NrDevices; d++) begin
            if (head_entry.target == IdxW'(d)) begin
                rsp_valid = device_rvalid_i[d];
                rsp_rdata = device_rdata_i[d];
                rsp_err   = device_err_i[d];
            end
        end
        pop = !rst_i && rsp_valid && (out_count != '0);
    end

    // Route the popped response back to the host at the FIFO head
    always_comb begin
        for (int h = 0; h < NrHosts; h++) begin
            host_rvalid_o[h] = pop && (head_entry.host == IdxW'(h));
            host_rdata_o[h]  = host_rvalid_o[h] ? rsp_rdata : '0;
            host_err_o[h]    = host_rvalid_o[h] && rsp_err;
        end
    end

    // Next-state for arbitration pointer, in-flight target and error responder
    always_comb begin
        last_gnt_d   = gnt_valid ? gnt_host : last_gnt_q;
        cur_target_d = gnt_valid ? gnt_tgt  : cur_target_q;
        err_rvalid_d = gnt_valid && (gnt_tgt == TgtW'(ErrTgt));
    end

    // Bus control registers; host 0 has first round-robin priority after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt_q   <= HostW'(NrHosts - 1);
            cur_target_q <= '0;
            err_rvalid_q <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            cur_target_q <= cur_target_d;
            err_rvalid_q <= err_rvalid_d;
        end
    end

    // Flag device responses that cannot belong to the in-flight transaction
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int d = 0; d < NrDevices; d++) begin
                assert (!device_rvalid_i[d] || ((out_count != '0) && (cur_target_q == TgtW'(d))))
                    else $error("bus_shared_rr: ignored device_rvalid_i from device %0d", d);
            end
        end
    end

endmodule
